// File: rtl/ddr_bundle_scheduler_pkg.sv
// Shared encodings for the DDR bundle scheduler: uop flag positions, timing defaults,
// and the self-refresh FSM state type.
package ddr_bundle_scheduler_pkg;

    localparam int unsigned DDR_UOP_WIDTH = 8;
    localparam int unsigned BUNDLE_W      = 4 * DDR_UOP_WIDTH;

    // Control flag bit positions within a uop; only slot 0 is decoded by the scheduler
    localparam int unsigned IS_SRE = 7;
    localparam int unsigned IS_SRX = 6;
    localparam int unsigned IS_NOP = 5;

    localparam int unsigned DEF_T_CKESR = 8;
    localparam int unsigned DEF_T_XS    = 16;

    localparam logic [DDR_UOP_WIDTH-1:0] UOP_NOP  = 8'h20;
    localparam logic [DDR_UOP_WIDTH-1:0] UOP_SRE  = 8'h80;
    localparam logic [DDR_UOP_WIDTH-1:0] UOP_SRX  = 8'h40;
    localparam logic [DDR_UOP_WIDTH-1:0] UOP_ACT  = 8'h01;
    localparam logic [DDR_UOP_WIDTH-1:0] UOP_READ = 8'h02;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StSrEntry = 2'd1,
        StSr      = 2'd2,
        StSrExit  = 2'd3
    } sched_state_e;

    function automatic logic slot0_flag(input logic [BUNDLE_W-1:0] bundle,
                                        input int unsigned pos);
        return bundle[pos];
    endfunction

    function automatic logic slot0_is_nop(input logic [BUNDLE_W-1:0] bundle);
        return bundle[IS_NOP];
    endfunction

endpackage

// File: rtl/uop_bundle_fifo.sv
// Bundle FIFO with occupancy count; the caller guarantees no push when full and no pop
// when empty.
module uop_bundle_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_occupancy,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && i_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata     = r_mem[r_rptr];
    assign o_occupancy = r_count;
    assign o_full      = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty     = (r_count == '0);

endmodule

// File: rtl/ddr_bundle_scheduler.sv
// Issues queued DDR bundles to the PHY, holding issue off across self-refresh entry and
// exit windows and flagging illegal SRE/SRX ordering.
module ddr_bundle_scheduler
    import ddr_bundle_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned T_CKESR = DEF_T_CKESR,
    parameter int unsigned T_XS    = DEF_T_XS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [BUNDLE_W-1:0]      in_bundle,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [BUNDLE_W-1:0]      out_bundle,
    input  logic                     phy_ready,
    output logic                     sr_active,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     seq_err
);
    localparam int unsigned CNT_W = $clog2((T_XS > T_CKESR) ? T_XS : T_CKESR) + 1;

    sched_state_e        r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_seq_err;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_offer;
    logic                w_head_sre;
    logic                w_head_srx;
    logic [BUNDLE_W-1:0] w_head;

    uop_bundle_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BUNDLE_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_wdata     (in_bundle),
        .o_rdata     (w_head),
        .o_occupancy (occupancy),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign w_head_sre = slot0_flag(w_head, IS_SRE);
    assign w_head_srx = slot0_flag(w_head, IS_SRX);

    always_comb begin
        w_offer = 1'b0;
        unique case (r_state)
            StRun:   w_offer = !w_empty;
            StSr:    w_offer = !w_empty && w_head_srx;
            default: w_offer = 1'b0;
        endcase
    end

    assign in_ready   = !w_full;
    assign w_push     = in_valid && in_ready;
    assign w_pop      = w_offer && phy_ready;
    assign out_valid  = w_offer;
    assign out_bundle = w_offer ? w_head : '0;
    assign sr_active  = (r_state != StRun);
    assign seq_err    = r_seq_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StRun;
            r_cnt     <= '0;
            r_seq_err <= 1'b0;
        end else begin
            // An SRE reaching the head outside RUN can never be legal
            if ((r_state != StRun) && !w_empty && w_head_sre) r_seq_err <= 1'b1;
            unique case (r_state)
                StRun: begin
                    if (w_pop && w_head_sre) begin
                        r_state <= StSrEntry;
                        r_cnt   <= CNT_W'(T_CKESR - 1);
                    end else if (w_pop && w_head_srx) begin
                        r_seq_err <= 1'b1;
                    end
                end
                StSrEntry: begin
                    if (r_cnt == '0) r_state <= StSr;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                StSr: begin
                    if (w_pop) begin
                        r_state <= StSrExit;
                        r_cnt   <= CNT_W'(T_XS - 1);
                    end
                end
                StSrExit: begin
                    if (r_cnt == '0) r_state <= StRun;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= StRun;
            endcase
        end
    end

endmodule
